// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared state encoding and constants for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int PERF_W    = 32;

  // Saturating increment used by the performance counters.
  function automatic logic [PERF_W-1:0] perf_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) return v + PERF_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/stall_perf_counters.sv
// rtl/stall_perf_counters.sv - saturating stall/flush/mem-wait cycle counters (STALL_PERF_EN only)
module stall_perf_counters
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              perf_clr,
  input  logic              load_evt,
  input  logic              flush_evt,
  input  logic              wait_evt,
  output logic [PERF_W-1:0] perf_load_stalls,
  output logic [PERF_W-1:0] perf_flush_cycles,
  output logic [PERF_W-1:0] perf_mem_wait_cycles
);

  logic [PERF_W-1:0] load_q, load_d;
  logic [PERF_W-1:0] flush_q, flush_d;
  logic [PERF_W-1:0] wait_q, wait_d;

  // Next counts: a clear wins over any increment in the same cycle.
  always_comb begin
    load_d  = perf_inc(load_q, load_evt);
    flush_d = perf_inc(flush_q, flush_evt);
    wait_d  = perf_inc(wait_q, wait_evt);
    if (perf_clr) begin
      load_d  = '0;
      flush_d = '0;
      wait_d  = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= '0;
      flush_q <= '0;
      wait_q  <= '0;
    end else begin
      load_q  <= load_d;
      flush_q <= flush_d;
      wait_q  <= wait_d;
    end
  end

  assign perf_load_stalls     = load_q;
  assign perf_flush_cycles    = flush_q;
  assign perf_mem_wait_cycles = wait_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush/freeze sequencer for a 5-stage pipeline; STALL_PERF_EN adds perf counters
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 64,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hazard_req,
  input  logic branch_taken_ex,
  input  logic mem_busy,
  output logic pc_write,
  output logic ifid_write,
  output logic ifid_flush,
  output logic idex_bubble,
  output logic exmem_hold,
  output logic stall_active,
  output logic wait_timeout
`ifdef STALL_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] perf_load_stalls,
  output logic [PERF_W-1:0] perf_flush_cycles,
  output logic [PERF_W-1:0] perf_mem_wait_cycles
`endif
);

  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);
  localparam logic [CNT_W-1:0] PEN_V     = CNT_W'(BRANCH_PENALTY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_timeout_q, wait_timeout_d;

  // Next state and pipeline controls; a busy data memory freezes from any state,
  // otherwise RUN resolves branch over hazard and the other states play out their sequence.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wait_timeout_d = wait_timeout_q;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    exmem_hold     = 1'b0;
    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      state_d    = MEM_WAIT;
      if (state_q == MEM_WAIT) begin
        cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + ONE_V;
      end else begin
        cnt_d = ONE_V;
      end
      if (cnt_d == TIMEOUT_V) wait_timeout_d = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken_ex) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              state_d = FLUSH;
              cnt_d   = PEN_V;
            end
          end else if (hazard_req) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            state_d     = LOAD_STALL;
          end
        end
        LOAD_STALL: state_d = RUN;
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (cnt_q <= ONE_V) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE_V;
          end
        end
        MEM_WAIT: begin
          state_d = RUN;
          cnt_d   = '0;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and sticky timeout registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      wait_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wait_timeout_q <= wait_timeout_d;
    end
  end

  assign stall_active = ~pc_write | ifid_flush | exmem_hold;
  assign wait_timeout = wait_timeout_q;

`ifdef STALL_PERF_EN
  logic load_evt;
  assign load_evt = (state_q == RUN) & ~mem_busy & ~branch_taken_ex & hazard_req;

  stall_perf_counters u_perf (
    .clk                  (clk),
    .rst_n                (rst_n),
    .perf_clr             (perf_clr),
    .load_evt             (load_evt),
    .flush_evt            (ifid_flush),
    .wait_evt             (exmem_hold),
    .perf_load_stalls     (perf_load_stalls),
    .perf_flush_cycles    (perf_flush_cycles),
    .perf_mem_wait_cycles (perf_mem_wait_cycles)
  );
`endif

endmodule
